uart_tx_sched: RTL
==================

# uart_tx_sched

Two-requester transmit scheduler for the 8-bit UART. Arbitrates round-robin between two byte sources, owns the `bps_start` enable of the baud-rate generator, and serialises the granted byte onto `tx`. Bit boundaries come from the generator's one-cycle `clk_bps` tick. A watchdog aborts the frame if ticks stop arriving.

## Interface
- `TIMEOUT_W`, default 10: width of the tick watchdog counter. A timeout fires after 2^TIMEOUT_W − 1 cycles with no `clk_bps` while sending.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset, synchronous and active-high.
- `req0` in 1: requester 0 has a byte; held until `ack0`.
- `data0` in 8: requester 0 byte; stable while `req0` is high.
- `ack0` out 1: one-cycle pulse; `data0` captured.
- `req1` in 1: requester 1 has a byte; held until `ack1`.
- `data1` in 8: requester 1 byte; stable while `req1` is high.
- `ack1` out 1: one-cycle pulse; `data1` captured.
- `bps_start` out 1: baud generator run enable; high for the whole frame.
- `clk_bps` in 1: one-cycle baud tick from the generator.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high from grant until return to IDLE.
- `owner` out 1: index of the requester currently or most recently granted.
- `done` out 1: one-cycle pulse when a frame completes normally.
- `err` out 1: one-cycle pulse on watchdog abort.

## Operation
- States:
  - IDLE: `tx`=1, `bps_start`=0, `busy`=0.
  - SEND: frame in progress.
  - FIN: one cycle; `done` pulses here.
- IDLE arbitration, evaluated every IDLE cycle:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the index ≠ `last`, where `last` is the previously granted index.
  - On grant at the next edge: capture data into the shift register; pulse `ackN`; set `owner`=`last`=N; set `bps_start`=1 and `busy`=1; enter SEND with bit index k=0.
- Frame bits, k = 0..F−1:
  - Bit 0: start bit (0).
  - Bits 1–8: data, LSB first.
  - Optional parity bit (see Configuration).
  - Final bit: stop bit (1).
  - F = 10 by default, 11 with parity.
- In SEND, on each `clk_bps`:
  - k < F: drive frame bit k on `tx`, then k ← k+1.
  - k == F: the stop bit's full period has elapsed. Deassert `bps_start`, keep `tx`=1, enter FIN.
- FIN → IDLE unconditionally. `busy` drops entering IDLE.
- Watchdog:
  - Counter clears on every `clk_bps` and in IDLE; otherwise it increments while in SEND.
  - Reaching all-ones: `tx`←1, `bps_start`←0, pulse `err`, go to IDLE. No `done`, and `last` is kept.
- `clk_bps` in IDLE or FIN is ignored.
- A request arriving while busy stays pending, with no ack, until IDLE.
- `req` and `data` are sampled only in IDLE. Changes while busy have no effect.

## Timing
- Reset values: `tx`=1, `bps_start`=0, `ack0`=`ack1`=0, `busy`=0, `owner`=0, `done`=0, `err`=0, state=IDLE, `last`=1, so req0 wins the first tie.
- Request to ack/bps_start latency is 1 cycle: request seen in IDLE at edge n gives `ackN`, `bps_start` and `busy` high after edge n+1.
- `tx` changes exactly on the cycle after each `clk_bps` edge. The start bit appears on the first tick after `bps_start` rises.
- `done` comes 1 cycle after the (F+1)th tick. IDLE then lasts ≥1 cycle before the next grant, so back-to-back frames have one extra idle cycle.
- `ackN` and `done` never occur in the same cycle.
- `rst` mid-frame: all outputs return to their reset values at the next edge. The frame is abandoned with no `done` or `err`.

## Configuration
- `UART_PARITY_EN` defined:
  - F = 11; bit 9 is even parity (XOR of the 8 data bits) and bit 10 is stop.
  - `done` follows the 12th tick.
- `UART_PARITY_EN` undefined: F = 10, no parity bit, and `done` follows the 11th tick.

## Test plan
- **Single byte.** req0 with data0=8'hA5; bench ticks every 434 cycles, first tick 217 cycles after `bps_start`. Expect: `ack0` at cycle+1; `tx` = 0,1,0,1,0,0,1,0,1,1; `done` after tick 11; `owner`=0.
- **Tie, then alternation.** req0 and req1 both high from reset with 8'h11 and 8'h22. Expect: grant order 0, 1, 0, 1 over four frames while both are held; exactly one ack per frame.
- **Pending request.** req1 raised mid-frame of req0 = 8'h0F. Expect: no `ack1` until IDLE; `ack1` 1 cycle after IDLE is entered; the 8'h0F stop bit completes unchanged.
- **Watchdog.** `TIMEOUT_W`=4; stop ticks after tick 3. Expect: `err` pulse 15 cycles after the last tick; `tx`=1, `bps_start`=0, `busy`=0; no `done`.
- **Reset mid-frame.** `rst` high one cycle during data bit 4. Expect: next cycle `tx`=1, `bps_start`=0, `busy`=0; a subsequent tie is won by req0.
- **Parity.** With `UART_PARITY_EN` defined, send 8'h07. Expect: frame bit 9 = 1, bit 10 = 1, `done` after tick 12.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin two-requester UART transmitter with clk_bps watchdog.
// Define UART_PARITY_EN to insert an even parity bit before the stop bit.
module uart_tx_sched #(
  parameter int TIMEOUT_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       bps_start,
  input  logic       clk_bps,
  output logic       tx,
  output logic       busy,
  output logic       owner,
  output logic       done,
  output logic       err
);
`ifdef UART_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
  state_t state, state_n;
  logic [7:0] sh, sh_n;
  logic [3:0] k, k_n;
  logic [TIMEOUT_W-1:0] wd, wd_n;
  logic [F-1:0] frame;
  logic last, last_n, g0, g1;
  logic tx_n, bps_n, ack0_n, ack1_n, busy_n, owner_n, done_n, err_n;
`ifdef UART_PARITY_EN
  assign frame = {1'b1, ^sh, sh, 1'b0};
`else
  assign frame = {1'b1, sh, 1'b0};
`endif
  // On a tie the requester not granted last time wins
  assign g0 = req0 & (~req1 | last);
  assign g1 = req1 & (~req0 | ~last);
  always_comb begin
    state_n = state;
    sh_n = sh;
    k_n = k;
    wd_n = wd;
    last_n = last;
    owner_n = owner;
    tx_n = tx;
    bps_n = bps_start;
    busy_n = busy;
    ack0_n = 1'b0;
    ack1_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        wd_n = '0;
        tx_n = 1'b1;
        bps_n = g0 | g1;
        busy_n = g0 | g1;
        if (g0 | g1) begin
          sh_n = g1 ? data1 : data0;
          ack0_n = g0;
          ack1_n = g1;
          owner_n = g1;
          last_n = g1;
          k_n = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (clk_bps) begin
          wd_n = '0;
          // The tick after the stop bit marks the end of its full period
          if (k == 4'(F)) begin
            tx_n = 1'b1;
            bps_n = 1'b0;
            done_n = 1'b1;
            state_n = FIN;
          end else begin
            tx_n = frame[k];
            k_n = k + 4'd1;
          end
        end else begin
          wd_n = wd + TIMEOUT_W'(1);
          if (&wd_n) begin
            tx_n = 1'b1;
            bps_n = 1'b0;
            busy_n = 1'b0;
            err_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      FIN: begin
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      k <= '0;
      wd <= '0;
      last <= 1'b1;
      owner <= 1'b0;
      tx <= 1'b1;
      bps_start <= 1'b0;
      busy <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      k <= k_n;
      wd <= wd_n;
      last <= last_n;
      owner <= owner_n;
      tx <= tx_n;
      bps_start <= bps_n;
      busy <= busy_n;
      ack0 <= ack0_n;
      ack1 <= ack1_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule
